// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with runtime baud divisor, parity and stop-bit format.
// Define UART_TX_CTS_EN to gate frame starts on active-low cts_pad_i.
module uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [DATA_W-1:0]             tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    input  logic [DIV_W-1:0]              divisor_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          stop2_i,
    input  logic                          cts_pad_i,
    output logic                          stx_pad_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   tf_count_o,
    output logic                          tx_done_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       fcnt_q, fcnt_d;
    logic [DATA_W-1:0] shr_q, shr_d;
    logic [DIV_W-1:0]  rld_q, rld_d, tmr_q, tmr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              par_en_q, par_en_d, par_q, par_d, stop2_q, stop2_d;
    logic              sec_q, sec_d, tx_q, tx_d, done_q, done_d;
    logic              push, tick, launch, cts_ok, stop_end;

`ifdef UART_TX_CTS_EN
    assign cts_ok = !cts_pad_i;
`else
    logic unused_cts;
    assign unused_cts = cts_pad_i;
    assign cts_ok     = 1'b1;
`endif

    assign tx_ready_o = fcnt_q != (AW+1)'(FIFO_DEPTH);
    assign push       = tx_valid_i && tx_ready_o;
    assign tick       = tmr_q == '0;
    assign stop_end   = state_q == STOP && tick && !(stop2_q && !sec_q);
    // a new frame may start from IDLE or straight out of the final stop bit
    assign launch     = fcnt_q != '0 && cts_ok && (state_q == IDLE || stop_end);

    always_comb begin
        state_d  = state_q;
        shr_d    = shr_q;
        rld_d    = rld_q;
        tmr_d    = tick ? rld_q : tmr_q - DIV_W'(1);
        bit_d    = bit_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        sec_d    = sec_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        wr_d     = push ? wr_q + AW'(1) : wr_q;
        rd_d     = launch ? rd_q + AW'(1) : rd_q;
        fcnt_d   = fcnt_q + (AW+1)'(push) - (AW+1)'(launch);
        case (state_q)
            IDLE: ;
            START: if (tick) begin
                state_d = DATA;
                tx_d    = shr_q[0];
                shr_d   = shr_q >> 1;
                bit_d   = '0;
            end
            DATA: if (tick) begin
                if (bit_q == BW'(DATA_W-1)) begin
                    state_d = par_en_q ? PARITY : STOP;
                    tx_d    = par_en_q ? par_q : 1'b1;
                    sec_d   = 1'b0;
                end else begin
                    bit_d = bit_q + BW'(1);
                    tx_d  = shr_q[0];
                    shr_d = shr_q >> 1;
                end
            end
            PARITY: if (tick) begin
                state_d = STOP;
                tx_d    = 1'b1;
                sec_d   = 1'b0;
            end
            STOP: if (tick) begin
                sec_d   = 1'b1;
                done_d  = stop_end;
                state_d = stop_end ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d  = START;
            shr_d    = mem_q[rd_q];
            rld_d    = divisor_i == '0 ? '0 : divisor_i - DIV_W'(1);
            tmr_d    = divisor_i == '0 ? '0 : divisor_i - DIV_W'(1);
            par_en_d = parity_en_i;
            par_d    = ^mem_q[rd_q] ^ parity_odd_i;
            stop2_d  = stop2_i;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            fcnt_q   <= '0;
            shr_q    <= '0;
            rld_q    <= '0;
            tmr_q    <= '0;
            bit_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            sec_q    <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            fcnt_q   <= fcnt_d;
            shr_q    <= shr_d;
            rld_q    <= rld_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            sec_q    <= sec_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push && !wb_rst_i) mem_q[wr_q] <= tx_data_i;
    end

    assign stx_pad_o  = tx_q;
    assign busy_o     = state_q != IDLE;
    assign tf_count_o = fcnt_q;
    assign tx_done_o  = done_q;
endmodule
